// File: rtl/slfifo_sched_pkg.sv
// Shared definitions for the FX3 slave-FIFO sequencer: endpoint address codes,
// sequencer states and local channel identifiers.
package slfifo_sched_pkg;

  localparam logic [1:0] AD_DF2U = 2'b00;
  localparam logic [1:0] AD_CU2F = 2'b01;
  localparam logic [1:0] AD_DU2F = 2'b11;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_TURN  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_CU2F = 2'd1,
    CH_DU2F = 2'd2,
    CH_DF2U = 2'd3
  } chan_t;

  function automatic logic [1:0] chan_ad(input chan_t ch);
    case (ch)
      CH_CU2F: return AD_CU2F;
      CH_DU2F: return AD_DU2F;
      default: return AD_DF2U;
    endcase
  endfunction

endpackage

// File: rtl/slfifo_rr_arb.sv
// Channel arbiter: command-in has fixed priority, data-in and data-out share a
// round-robin pointer that only moves when one of their bursts completes.
module slfifo_rr_arb
  import slfifo_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_c,
  input  logic  req_d,
  input  logic  req_w,
  input  logic  sample,
  input  logic  done,
  output logic  gnt_valid,
  output chan_t gnt_chan
);

  logic  favor_w_reg;
  chan_t owner_reg;

  always_comb begin
    gnt_chan = CH_NONE;
    if (req_c)
      gnt_chan = CH_CU2F;
    else if (req_d && req_w)
      gnt_chan = favor_w_reg ? CH_DF2U : CH_DU2F;
    else if (req_d)
      gnt_chan = CH_DU2F;
    else if (req_w)
      gnt_chan = CH_DF2U;
    gnt_valid = sample && (gnt_chan != CH_NONE);
  end

  // The pointer favours whichever of D/W did not own the burst just finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favor_w_reg <= 1'b0;
      owner_reg   <= CH_NONE;
    end else begin
      if (gnt_valid)
        owner_reg <= gnt_chan;
      if (done) begin
        if (owner_reg == CH_DU2F)
          favor_w_reg <= 1'b1;
        else if (owner_reg == CH_DF2U)
          favor_w_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/slfifo_sched.sv
// FX3 synchronous slave-FIFO sequencer: grants the SL bus to CU2F/DU2F (reads)
// or DF2U (writes) one burst at a time and moves words to/from the local FIFOs.
module slfifo_sched
  import slfifo_sched_pkg::*;
#(
  parameter int BURST   = 16,
  parameter int RD_LAT  = 2,
  parameter int AD_WAIT = 1,
  parameter int TURN    = 1
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        SL_FLAGA,
  input  logic        SL_FLAGB,
  input  logic        SL_FLAGC,
  output logic        SL_CS_N,
  output logic        SL_RD_N,
  output logic        SL_OE_N,
  output logic        SL_WR_N,
  output logic        SL_PKTEND_N,
  output logic [1:0]  SL_AD,
  input  logic [31:0] SL_DT_I,
  output logic [31:0] SL_DT_O,
  output logic        SL_DT_T,
  input  logic [15:0] cu2f_room,
  output logic        cu2f_wr,
  output logic [31:0] cu2f_wdata,
  input  logic [15:0] du2f_room,
  output logic        du2f_wr,
  output logic [31:0] du2f_wdata,
  input  logic [15:0] df2u_items,
  input  logic [31:0] df2u_rdata,
  output logic        df2u_rd,
  input  logic        df2u_flush
);

  if (BURST < 1 || BURST > 65535) begin : g_chk_burst
    $error("slfifo_sched: BURST must be in 1..65535");
  end
  if (RD_LAT < 1 || AD_WAIT < 0 || TURN < 1) begin : g_chk_timing
    $error("slfifo_sched: need RD_LAT>=1, AD_WAIT>=0, TURN>=1");
  end

  localparam logic [CNT_W-1:0] BURST_W    = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'((AD_WAIT > 0) ? AD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  chan_t             chan_reg;
  logic [1:0]        ad_reg;
  logic [CNT_W-1:0]  wr_len_reg;
  logic              pkt_end_reg;
  logic              cs_n_reg;
  logic [RD_LAT-1:0] strobe_sr_reg;
  logic              push_reg;
  logic [31:0]       dt_reg;

  logic  elig_c, elig_d, elig_w, short_w;
  logic  sample, done, gnt_valid, wr_last;
  chan_t gnt_chan;

  assign short_w = df2u_items < BURST_W;
  assign elig_c  = SL_FLAGB && (cu2f_room >= BURST_W);
  assign elig_d  = SL_FLAGC && (du2f_room >= BURST_W);
  assign elig_w  = SL_FLAGA && (!short_w || (df2u_flush && (df2u_items != '0)));

  slfifo_rr_arb u_arb (
    .clk       (SYS_CLK),
    .rst       (SYS_RST),
    .req_c     (elig_c),
    .req_d     (elig_d),
    .req_w     (elig_w),
    .sample    (sample),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_chan  (gnt_chan)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    sample     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        sample   = 1'b1;
        if (gnt_valid) begin
          // With no address setup time the strobe phase follows the grant directly.
          if (AD_WAIT == 0)
            state_next = (gnt_chan == CH_DF2U) ? ST_WR : ST_RD;
          else
            state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (cnt_reg == AD_LAST) begin
          cnt_next   = '0;
          state_next = (chan_reg == CH_DF2U) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (cnt_reg == BURST_LAST) begin
          cnt_next   = '0;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == LAT_LAST) begin
          cnt_next   = '0;
          state_next = ST_TURN;
        end
      end
      ST_WR: begin
        if (wr_last) begin
          cnt_next   = '0;
          state_next = ST_TURN;
        end
      end
      ST_TURN: begin
        if (cnt_reg == TURN_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
          done       = 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cs_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cs_n_reg  <= 1'b0;
    end
  end

  // Burst parameters are frozen at grant so later flag/level changes cannot cut a burst.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      chan_reg    <= CH_NONE;
      ad_reg      <= AD_DF2U;
      wr_len_reg  <= '0;
      pkt_end_reg <= 1'b0;
    end else if (gnt_valid) begin
      chan_reg    <= gnt_chan;
      ad_reg      <= chan_ad(gnt_chan);
      wr_len_reg  <= short_w ? df2u_items : BURST_W;
      pkt_end_reg <= short_w || (df2u_flush && (df2u_items == BURST_W));
    end
  end

  // Read strobes are delayed RD_LAT cycles to meet the FX3 data, which is then
  // registered, so each push lands RD_LAT+1 cycles after its strobe.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      strobe_sr_reg <= '0;
      push_reg      <= 1'b0;
      dt_reg        <= '0;
    end else begin
      strobe_sr_reg[0] <= (state_reg == ST_RD);
      for (int i = 1; i < RD_LAT; i++)
        strobe_sr_reg[i] <= strobe_sr_reg[i-1];
      push_reg <= strobe_sr_reg[RD_LAT-1];
      if (strobe_sr_reg[RD_LAT-1])
        dt_reg <= SL_DT_I;
    end
  end

  assign wr_last     = (cnt_reg == wr_len_reg - CNT_W'(1));
  assign SL_CS_N     = cs_n_reg;
  assign SL_RD_N     = (state_reg != ST_RD);
  assign SL_OE_N     = (state_reg != ST_RD);
  assign SL_WR_N     = (state_reg != ST_WR);
  assign SL_PKTEND_N = !((state_reg == ST_WR) && pkt_end_reg && wr_last);
  assign SL_AD       = ad_reg;
  assign SL_DT_T     = (state_reg != ST_WR);
  assign SL_DT_O     = (state_reg == ST_WR) ? df2u_rdata : '0;
  assign df2u_rd     = (state_reg == ST_WR);
  assign cu2f_wr     = push_reg && (chan_reg == CH_CU2F);
  assign du2f_wr     = push_reg && (chan_reg == CH_DU2F);
  assign cu2f_wdata  = dt_reg;
  assign du2f_wdata  = dt_reg;

endmodule

// File: tb/tb_slfifo_sched.sv
// Self-checking bench for slfifo_sched: table of single-burst vectors plus
// hand sequences for round-robin/priority and reset in the middle of a burst.
module tb_slfifo_sched;

  localparam int BURST   = 16;
  localparam int RD_LAT  = 2;
  localparam int AD_WAIT = 1;
  localparam logic [31:0] FX_BASE = 32'hA500_0000;
  localparam logic [31:0] DF_BASE = 32'hD000_0000;

  logic        SYS_CLK, SYS_RST;
  logic        SL_FLAGA, SL_FLAGB, SL_FLAGC;
  logic        SL_CS_N, SL_RD_N, SL_OE_N, SL_WR_N, SL_PKTEND_N;
  logic [1:0]  SL_AD;
  logic [31:0] SL_DT_I, SL_DT_O;
  logic        SL_DT_T;
  logic [15:0] cu2f_room, du2f_room, df2u_items;
  logic        cu2f_wr, du2f_wr, df2u_rd, df2u_flush;
  logic [31:0] cu2f_wdata, du2f_wdata, df2u_rdata;

  slfifo_sched #(.BURST(BURST), .RD_LAT(RD_LAT), .AD_WAIT(AD_WAIT), .TURN(1)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
    .SL_FLAGA(SL_FLAGA), .SL_FLAGB(SL_FLAGB), .SL_FLAGC(SL_FLAGC),
    .SL_CS_N(SL_CS_N), .SL_RD_N(SL_RD_N), .SL_OE_N(SL_OE_N), .SL_WR_N(SL_WR_N),
    .SL_PKTEND_N(SL_PKTEND_N), .SL_AD(SL_AD), .SL_DT_I(SL_DT_I), .SL_DT_O(SL_DT_O),
    .SL_DT_T(SL_DT_T), .cu2f_room(cu2f_room), .cu2f_wr(cu2f_wr), .cu2f_wdata(cu2f_wdata),
    .du2f_room(du2f_room), .du2f_wr(du2f_wr), .du2f_wdata(du2f_wdata),
    .df2u_items(df2u_items), .df2u_rdata(df2u_rdata), .df2u_rd(df2u_rd),
    .df2u_flush(df2u_flush)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  // FX3 read model: a counting word appears RD_LAT cycles after each RD strobe.
  logic [31:0] fx_pipe [RD_LAT];
  int fx_idx = 0;
  always @(posedge SYS_CLK) begin
    if (!SL_RD_N) begin
      fx_pipe[0] <= FX_BASE + 32'(fx_idx);
      fx_idx     <= fx_idx + 1;
    end else begin
      fx_pipe[0] <= 32'hDEAD_0000;
    end
    for (int i = 1; i < RD_LAT; i++) fx_pipe[i] <= fx_pipe[i-1];
  end
  assign SL_DT_I = fx_pipe[RD_LAT-1];

  // DF2U first-word-fall-through model.
  int df_head = 0;
  always @(posedge SYS_CLK) if (df2u_rd) df_head <= df_head + 1;
  assign df2u_rdata = DF_BASE + 32'(df_head);

  int checks = 0, failures = 0;
  int exp_push = 0, push_c = 0, push_d = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_monitor();
    forever begin
      @(negedge SYS_CLK);
      if (SYS_RST) begin
        exp_push = fx_idx;
      end else begin
        if (cu2f_wr) begin
          check("cu2f_data", cu2f_wdata, FX_BASE + 32'(exp_push));
          exp_push++; push_c++;
        end
        if (du2f_wr) begin
          check("du2f_data", du2f_wdata, FX_BASE + 32'(exp_push));
          exp_push++; push_d++;
        end
      end
    end
  endtask

  // ch: 0 none, 1 CU2F, 2 DU2F, 3 DF2U
  typedef struct {
    int fa, fb, fc, croom, droom, items, flush;
    int ch, len, ad, pkt;
  } vec_t;
  vec_t vecs [14];

  task automatic run_vec(input vec_t v, input int id);
    int lat = 0, rd_lo = 0, oe_lo = 0, wr_idx = 0, pkt_lo = 0, pkt_last = 0;
    int dtt_lo = 0, pops = 0, dto_err = 0, pc0, pd0, df0, rd_exp, wr_exp;
    bit got = 0;
    SL_FLAGA = v.fa[0]; SL_FLAGB = v.fb[0]; SL_FLAGC = v.fc[0];
    cu2f_room = 16'(v.croom); du2f_room = 16'(v.droom);
    df2u_items = 16'(v.items); df2u_flush = v.flush[0];
    pc0 = push_c; pd0 = push_d;
    while (lat < 12 && !got) begin
      @(negedge SYS_CLK); lat++;
      if (!SL_RD_N || !SL_WR_N) got = 1;
    end
    if (v.len == 0) begin
      check($sformatf("v%0d_nogrant", id), 32'(got), 32'd0);
      return;
    end
    check($sformatf("v%0d_latency", id), 32'(lat), 32'(1 + AD_WAIT));
    check($sformatf("v%0d_ad", id), 32'(SL_AD), 32'(v.ad));
    SL_FLAGA = 1'b0; SL_FLAGB = 1'b0; SL_FLAGC = 1'b0;
    df0 = df_head;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) @(negedge SYS_CLK);
      if (!SL_RD_N) rd_lo++;
      if (!SL_OE_N) oe_lo++;
      if (!SL_PKTEND_N) begin
        pkt_lo++;
        if (!SL_WR_N && wr_idx == v.len - 1) pkt_last++;
      end
      if (!SL_WR_N) begin
        if (SL_DT_O !== DF_BASE + 32'(df0 + wr_idx)) dto_err++;
        wr_idx++;
      end
      if (!SL_DT_T) dtt_lo++;
      if (df2u_rd) pops++;
    end
    rd_exp = (v.ch == 3) ? 0 : v.len;
    wr_exp = (v.ch == 3) ? v.len : 0;
    check($sformatf("v%0d_rd_cycles", id), 32'(rd_lo), 32'(rd_exp));
    check($sformatf("v%0d_oe_cycles", id), 32'(oe_lo), 32'(rd_exp));
    check($sformatf("v%0d_wr_cycles", id), 32'(wr_idx), 32'(wr_exp));
    check($sformatf("v%0d_dt_t_low", id), 32'(dtt_lo), 32'(wr_exp));
    check($sformatf("v%0d_pops", id), 32'(pops), 32'(wr_exp));
    check($sformatf("v%0d_dt_o_errs", id), 32'(dto_err), 32'd0);
    check($sformatf("v%0d_pktend_cnt", id), 32'(pkt_lo), 32'(v.pkt));
    check($sformatf("v%0d_pktend_last", id), 32'(pkt_last), 32'(v.pkt));
    check($sformatf("v%0d_cu2f_pushes", id), 32'(push_c - pc0), 32'((v.ch == 1) ? v.len : 0));
    check($sformatf("v%0d_du2f_pushes", id), 32'(push_d - pd0), 32'((v.ch == 2) ? v.len : 0));
    $display("vec %0d: ch=%0d len=%0d ad=%0d rd=%0d wr=%0d pkt=%0d", id, v.ch, v.len, SL_AD, rd_lo, wr_idx, pkt_lo);
  endtask

  task automatic next_burst(output logic [1:0] ad, output bit ok);
    int n = 0;
    ok = 0; ad = 2'b10;
    while ((!SL_RD_N || !SL_WR_N) && n < 40) begin @(negedge SYS_CLK); n++; end
    while (!ok && n < 120) begin
      @(negedge SYS_CLK); n++;
      if (!SL_RD_N || !SL_WR_N) begin ok = 1; ad = SL_AD; end
    end
    $display("burst: ad=%b ok=%0d", ad, ok);
  endtask

  logic [10:0] rst_vec;
  assign rst_vec = {SL_CS_N, SL_RD_N, SL_OE_N, SL_WR_N, SL_PKTEND_N, SL_DT_T, SL_AD,
                    cu2f_wr, du2f_wr, df2u_rd};

  initial begin
    logic [1:0] a, prev;
    bit ok;
    int strobes, n, pc0;

    //        fa fb fc croom droom items flush  ch len ad pkt
    vecs[0]  = '{0, 1, 0, 64, 0,  0,  0, 1, 16, 1, 0};
    vecs[1]  = '{0, 0, 1, 0,  16, 0,  0, 2, 16, 3, 0};
    vecs[2]  = '{0, 1, 0, 15, 0,  0,  0, 0, 0,  0, 0};
    vecs[3]  = '{0, 1, 0, 16, 0,  0,  0, 1, 16, 1, 0};
    vecs[4]  = '{1, 0, 0, 0,  0,  5,  1, 3, 5,  0, 1};
    vecs[5]  = '{1, 0, 0, 0,  0,  5,  0, 0, 0,  0, 0};
    vecs[6]  = '{1, 0, 0, 0,  0,  40, 0, 3, 16, 0, 0};
    vecs[7]  = '{1, 0, 0, 0,  0,  16, 1, 3, 16, 0, 1};
    vecs[8]  = '{1, 0, 0, 0,  0,  20, 1, 3, 16, 0, 0};
    vecs[9]  = '{1, 0, 0, 0,  0,  1,  1, 3, 1,  0, 1};
    vecs[10] = '{1, 0, 0, 0,  0,  0,  1, 0, 0,  0, 0};
    vecs[11] = '{0, 0, 1, 0,  15, 0,  0, 0, 0,  0, 0};
    vecs[12] = '{1, 1, 1, 64, 64, 40, 0, 1, 16, 1, 0};
    vecs[13] = '{0, 0, 0, 64, 64, 40, 1, 0, 0,  0, 0};

    SYS_RST = 1'b1;
    SL_FLAGA = 0; SL_FLAGB = 0; SL_FLAGC = 0;
    cu2f_room = 0; du2f_room = 0; df2u_items = 0; df2u_flush = 0;
    fork push_monitor(); join_none

    @(negedge SYS_CLK);
    check("reset_outputs", 32'(rst_vec), 32'(11'b111111_00_000));
    check("reset_dt_o", SL_DT_O, 32'd0);
    SYS_RST = 1'b0;
    @(negedge SYS_CLK);
    check("cs_n_after_reset", 32'(SL_CS_N), 32'd0);
    check("idle_rd_n", 32'(SL_RD_N), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Round-robin between DU2F and DF2U, then CU2F priority raised mid-DU2F burst.
    SL_FLAGC = 1; SL_FLAGA = 1; du2f_room = 64; cu2f_room = 64;
    df2u_items = 40; df2u_flush = 0;
    next_burst(prev, ok);
    check("alt_first_dw", 32'((prev == 2'b11) || (prev == 2'b00)), 32'd1);
    for (int i = 1; i < 4; i++) begin
      next_burst(a, ok);
      check($sformatf("alt_%0d", i), 32'(a), 32'((prev == 2'b11) ? 2'b00 : 2'b11));
      prev = a;
    end
    if (prev == 2'b00) begin
      next_burst(a, ok);
      check("alt_to_d", 32'(a), 32'(2'b11));
    end
    SL_FLAGB = 1;
    next_burst(a, ok);
    check("prio_cu2f", 32'(a), 32'(2'b01));
    SL_FLAGB = 0;
    next_burst(a, ok);
    check("after_cu2f_w", 32'(a), 32'(2'b00));
    SL_FLAGA = 0; SL_FLAGC = 0;
    repeat (40) @(negedge SYS_CLK);

    // Reset asserted during read strobe 7.
    SL_FLAGB = 1; cu2f_room = 64;
    strobes = 0; n = 0;
    while (strobes < 7 && n < 40) begin
      @(negedge SYS_CLK); n++;
      if (!SL_RD_N) strobes++;
    end
    check("rst_reach_rd7", 32'(strobes), 32'd7);
    #1 SYS_RST = 1'b1; SL_FLAGB = 0;
    #1;
    check("rst_mid_outputs", 32'(rst_vec), 32'(11'b111111_00_000));
    check("rst_mid_dt_o", SL_DT_O, 32'd0);
    $display("reset mid-burst at rd strobe %0d", strobes);
    pc0 = push_c;
    repeat (2) @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    repeat (12) @(negedge SYS_CLK);
    check("rst_no_push", 32'(push_c), 32'(pc0));
    run_vec(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
